// File: rtl/instr_image_loader_pkg.sv
// Shared definitions for the CPU instruction-image loader: image geometry,
// loader state encoding and small slot/count helpers.
package cpu_pkg;

   localparam int WORD_W    = 32;
   localparam int NUM_SLOTS = 10;
   // Derived width of the flat image bus; tied to the two values above.
   localparam int IMG_W     = NUM_SLOTS * WORD_W;

   localparam logic [WORD_W-1:0] NOP_WORD = 32'h0000_0000;
   localparam logic [3:0]        SLOT_MAX = 4'd10;

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      LOAD = 2'd1,
      PAD  = 2'd2,
      RUN  = 2'd3
   } state_t;

   // Lowest bit of slot k; slot 0 sits at the top of the image bus.
   function automatic int slot_base(input int k);
      return IMG_W - WORD_W * (k + 1);
   endfunction

   // Four-bit counter increment that saturates at the slot count.
   function automatic logic [3:0] sat_inc(input logic [3:0] v);
      if (v >= SLOT_MAX) begin
         return SLOT_MAX;
      end else begin
         return v + 4'd1;
      end
   endfunction

endpackage

// File: rtl/instr_image_loader_slot_writer.sv
// Storage for the packed instruction image. One slot can be written per
// cycle with either the incoming word or a nop; a clear zeroes every slot
// except the one being written in the same cycle.
module slot_writer
   import cpu_pkg::*;
(
   input  logic              clock,
   input  logic              reset,
   input  logic              clear,
   input  logic              wr_en,
   input  logic [3:0]        wr_slot,
   input  logic              wr_nop,
   input  logic [WORD_W-1:0] wr_data,
   output logic [IMG_W-1:0]  image
);

   logic [WORD_W-1:0]    slot_r [NUM_SLOTS];
   logic [NUM_SLOTS-1:0] hit_s;

   // Decode the write slot; indices outside the image select nothing.
   always_comb begin
      hit_s = '0;
      for (int k = 0; k < NUM_SLOTS; k++) begin
         if (wr_en && (wr_slot == 4'(k))) begin
            hit_s[k] = 1'b1;
         end else begin
            hit_s[k] = 1'b0;
         end
      end
   end

   // Slot registers: a write wins over a clear so the first word survives.
   always_ff @(posedge clock or posedge reset) begin
      if (reset) begin
         for (int k = 0; k < NUM_SLOTS; k++) begin
            slot_r[k] <= NOP_WORD;
         end
      end else begin
         for (int k = 0; k < NUM_SLOTS; k++) begin
            if (hit_s[k]) begin
               slot_r[k] <= wr_nop ? NOP_WORD : wr_data;
            end else if (clear) begin
               slot_r[k] <= NOP_WORD;
            end else begin
               slot_r[k] <= slot_r[k];
            end
         end
      end
   end

   for (genvar g = 0; g < NUM_SLOTS; g++) begin : g_pack
      localparam int BASE = slot_base(g);
      assign image[BASE +: WORD_W] = slot_r[g];
   end

endmodule

// File: rtl/instr_image_loader.sv
// Writer side of the CPU instr/start interface. Accepts instruction words
// over a valid/ready stream, packs them into the flat image, zero-pads the
// unused slots and then raises start until a run_stop request.
module instr_image_loader
   import cpu_pkg::*;
(
   input  logic              clock,
   input  logic              reset,
   input  logic              in_valid,
   output logic              in_ready,
   input  logic [WORD_W-1:0] in_data,
   input  logic              in_last,
   input  logic              run_stop,
   output logic [IMG_W-1:0]  instr,
   output logic              start,
   output logic [3:0]        words_loaded,
   output logic              busy
);

   state_t     state_r;
   state_t     state_next_s;
   logic [3:0] count_r;
   logic [3:0] count_next_s;
   logic [3:0] count_inc_s;
   logic [3:0] pad_idx_r;
   logic [3:0] pad_idx_next_s;
   logic       start_r;
   logic       in_ready_r;
   logic       busy_r;
   logic       xfer_s;
   logic       clear_s;
   logic       wr_en_s;
   logic       wr_nop_s;
   logic [3:0] wr_slot_s;

   assign xfer_s      = in_valid && in_ready_r;
   assign count_inc_s = sat_inc(count_r);

   // Next-state, counter updates and slot-write commands for the loader FSM.
   always_comb begin
      state_next_s   = state_r;
      count_next_s   = count_r;
      pad_idx_next_s = pad_idx_r;
      clear_s        = 1'b0;
      wr_en_s        = 1'b0;
      wr_nop_s       = 1'b0;
      wr_slot_s      = 4'd0;
      case (state_r)
         IDLE: begin
            if (xfer_s) begin
               clear_s        = 1'b1;
               wr_en_s        = 1'b1;
               wr_slot_s      = 4'd0;
               count_next_s   = 4'd1;
               pad_idx_next_s = 4'd1;
               if (in_last || (NUM_SLOTS == 1)) begin
                  state_next_s = PAD;
               end else begin
                  state_next_s = LOAD;
               end
            end else begin
               state_next_s = IDLE;
            end
         end
         LOAD: begin
            if (xfer_s) begin
               if (count_r < SLOT_MAX) begin
                  wr_en_s   = 1'b1;
                  wr_slot_s = count_r;
               end else begin
                  wr_en_s   = 1'b0;
               end
               count_next_s   = count_inc_s;
               pad_idx_next_s = count_inc_s;
               if (in_last || (count_inc_s == SLOT_MAX)) begin
                  state_next_s = PAD;
               end else begin
                  state_next_s = LOAD;
               end
            end else begin
               state_next_s = LOAD;
            end
         end
         PAD: begin
            // One nop slot per cycle; an exhausted index means the image is complete.
            if (pad_idx_r < SLOT_MAX) begin
               wr_en_s        = 1'b1;
               wr_nop_s       = 1'b1;
               wr_slot_s      = pad_idx_r;
               pad_idx_next_s = sat_inc(pad_idx_r);
               state_next_s   = PAD;
            end else begin
               state_next_s   = RUN;
            end
         end
         RUN: begin
            if (run_stop) begin
               state_next_s = IDLE;
            end else begin
               state_next_s = RUN;
            end
         end
         default: begin
            state_next_s = IDLE;
         end
      endcase
   end

   // State, counters and registered handshake/status outputs.
   always_ff @(posedge clock or posedge reset) begin
      if (reset) begin
         state_r    <= IDLE;
         count_r    <= 4'd0;
         pad_idx_r  <= 4'd0;
         start_r    <= 1'b0;
         in_ready_r <= 1'b1;
         busy_r     <= 1'b0;
      end else begin
         state_r    <= state_next_s;
         count_r    <= count_next_s;
         pad_idx_r  <= pad_idx_next_s;
         // start follows RUN one cycle late and drops on the stop edge.
         start_r    <= (state_r == RUN) && (state_next_s == RUN);
         in_ready_r <= (state_next_s == IDLE) || (state_next_s == LOAD);
         busy_r     <= (state_next_s == LOAD) || (state_next_s == PAD);
      end
   end

   slot_writer u_slot_writer (
      .clock   (clock),
      .reset   (reset),
      .clear   (clear_s),
      .wr_en   (wr_en_s),
      .wr_slot (wr_slot_s),
      .wr_nop  (wr_nop_s),
      .wr_data (in_data),
      .image   (instr)
   );

   assign in_ready     = in_ready_r;
   assign start        = start_r;
   assign words_loaded = count_r;
   assign busy         = busy_r;

endmodule

// File: tb/tb_instr_image_loader.sv
// Randomized scoreboard bench for instr_image_loader.
module tb_instr_image_loader;
   import cpu_pkg::*;

   logic              clock = 1'b0;
   logic              reset;
   logic              in_valid;
   logic              in_ready;
   logic [WORD_W-1:0] in_data;
   logic              in_last;
   logic              run_stop;
   logic [IMG_W-1:0]  instr;
   logic              start;
   logic [3:0]        words_loaded;
   logic              busy;

   instr_image_loader dut (
      .clock        (clock),
      .reset        (reset),
      .in_valid     (in_valid),
      .in_ready     (in_ready),
      .in_data      (in_data),
      .in_last      (in_last),
      .run_stop     (run_stop),
      .instr        (instr),
      .start        (start),
      .words_loaded (words_loaded),
      .busy         (busy)
   );

   always #5 clock = ~clock;

   int cyc = 0;
   always @(posedge clock) cyc <= cyc + 1;

   typedef struct {
      logic [IMG_W-1:0] img;
      logic [3:0]       cnt;
      int               start_cyc;
   } exp_t;

   exp_t              sb_q[$];
   logic [WORD_W-1:0] prog_q[$];
   int                n_pass  = 0;
   int                n_total = 0;
   int                last_acc = 0;

   task automatic check(input string name, input logic [IMG_W-1:0] got, input logic [IMG_W-1:0] exp);
      n_total++;
      if (got === exp) n_pass++;
      else $display("FAIL %s: got %0h expected %0h", name, got, exp);
   endtask

   // Monitor: every rising start presents a finished image to be scored.
   logic start_prev = 1'b0;
   exp_t mon_e;
   always @(negedge clock) begin
      if (start === 1'b1 && start_prev === 1'b0) begin
         if (sb_q.size() == 0) begin
            check("unexpected_start", IMG_W'(1), IMG_W'(0));
         end else begin
            mon_e = sb_q.pop_front();
            check("image", instr, mon_e.img);
            check("words_loaded", IMG_W'(words_loaded), IMG_W'(mon_e.cnt));
            check("start_latency", IMG_W'(cyc), IMG_W'(mon_e.start_cyc));
         end
      end
      start_prev = start;
   end

   // Offer one word (after a random gap) and wait for its handshake.
   task automatic send(input logic [WORD_W-1:0] w, input logic last);
      int waitc;
      repeat ($urandom_range(0, 2)) begin
         in_valid = 1'b0;
         in_data  = $urandom;
         in_last  = 1'($urandom_range(0, 1));
         run_stop = 1'($urandom_range(0, 1));
         @(negedge clock);
      end
      run_stop = 1'b0;
      in_valid = 1'b1;
      in_data  = w;
      in_last  = last;
      waitc    = 0;
      while (!in_ready && waitc < 20) begin
         @(negedge clock);
         waitc++;
      end
      if (waitc >= 20) check("ready_timeout", IMG_W'(0), IMG_W'(1));
      @(negedge clock);
      last_acc = cyc;
      in_valid = 1'b0;
      in_last  = 1'b0;
   endtask

   task automatic wait_start();
      int w = 0;
      while (start !== 1'b1 && w < 40) begin
         @(negedge clock);
         w++;
      end
      if (start !== 1'b1) check("start_timeout", IMG_W'(0), IMG_W'(1));
      @(negedge clock);
      check("sb_drained", IMG_W'(sb_q.size()), IMG_W'(0));
      check("run_in_ready", IMG_W'(in_ready), IMG_W'(0));
      check("run_busy", IMG_W'(busy), IMG_W'(0));
   endtask

   // Load prog_q[0..n-1]; the reference image is the words in order followed by nops.
   task automatic run_program(input int n, input bit use_last, input int hold_junk);
      exp_t e;
      int   cnt;
      for (int i = 0; i < n; i++) send(prog_q[i], use_last && (i == n - 1));
      cnt   = (n > NUM_SLOTS) ? NUM_SLOTS : n;
      e.img = '0;
      for (int i = 0; i < cnt; i++) e.img[IMG_W-1-WORD_W*i -: WORD_W] = prog_q[i];
      e.cnt       = 4'(cnt);
      e.start_cyc = last_acc + 1 + (NUM_SLOTS - cnt) + 1;
      sb_q.push_back(e);
      check("ready_after_last", IMG_W'(in_ready), IMG_W'(0));
      if (hold_junk > 0) begin
         in_valid = 1'b1;
         in_data  = $urandom;
         repeat (hold_junk) @(negedge clock);
         in_valid = 1'b0;
      end
      wait_start();
   endtask

   // Stop the CPU with a simultaneous (ignored) input word.
   task automatic stop_run();
      logic [IMG_W-1:0] img_before;
      logic [3:0]       wl_before;
      img_before = instr;
      wl_before  = words_loaded;
      run_stop   = 1'b1;
      in_valid   = 1'b1;
      in_data    = $urandom;
      @(negedge clock);
      run_stop = 1'b0;
      in_valid = 1'b0;
      check("stop_start", IMG_W'(start), IMG_W'(0));
      check("stop_image", instr, img_before);
      check("stop_words_loaded", IMG_W'(words_loaded), IMG_W'(wl_before));
      check("stop_ready", IMG_W'(in_ready), IMG_W'(1));
   endtask

   task automatic check_reset_state(input string tag);
      check({tag, "_instr"}, instr, '0);
      check({tag, "_start"}, IMG_W'(start), IMG_W'(0));
      check({tag, "_words_loaded"}, IMG_W'(words_loaded), IMG_W'(0));
      check({tag, "_ready"}, IMG_W'(in_ready), IMG_W'(1));
      check({tag, "_busy"}, IMG_W'(busy), IMG_W'(0));
   endtask

   initial begin
      #200000;
      $display("FAIL global_timeout: simulation did not finish");
      $fatal(1, "timeout");
   end

   initial begin
      int n;
      bit ul;
      reset    = 1'b1;
      in_valid = 1'b0;
      in_data  = '0;
      in_last  = 1'b0;
      run_stop = 1'b0;
      repeat (2) @(negedge clock);
      check_reset_state("reset");
      reset = 1'b0;
      @(negedge clock);

      // Nine-word program with in_last, junk held valid during PAD/RUN.
      prog_q = '{32'h20010003, 32'h20020005, 32'h00221820, 32'h20040002, 32'h00832022,
                 32'h20050001, 32'h00a43024, 32'h00c53825, 32'h00863822};
      run_program(9, 1'b1, 3);
      stop_run();

      // Full image without in_last; an 11th word is held but never taken.
      prog_q.delete();
      for (int i = 0; i < NUM_SLOTS; i++) prog_q.push_back($urandom);
      run_program(NUM_SLOTS, 1'b0, 4);
      stop_run();

      // Single word after a full image: the old contents must be cleared.
      prog_q = '{32'h20220001};
      run_program(1, 1'b1, 0);
      stop_run();

      prog_q = '{32'h08000001};
      run_program(1, 1'b1, 0);
      stop_run();

      // Random programs with random gaps and stray in_last/run_stop.
      for (int p = 0; p < 6; p++) begin
         n  = $urandom_range(1, NUM_SLOTS);
         ul = (n < NUM_SLOTS) ? 1'b1 : 1'($urandom_range(0, 1));
         prog_q.delete();
         for (int i = 0; i < n; i++) prog_q.push_back($urandom);
         run_program(n, ul, $urandom_range(0, 3));
         stop_run();
      end

      // Asynchronous reset in the middle of LOAD, then a normal reload.
      for (int i = 0; i < 4; i++) send($urandom, 1'b0);
      #2 reset = 1'b1;
      #1 check_reset_state("async_load");
      @(negedge clock);
      reset  = 1'b0;
      prog_q = '{32'h11111111, 32'h22222222, 32'h33333333};
      run_program(3, 1'b1, 0);

      // Asynchronous reset while running.
      #2 reset = 1'b1;
      #1 check_reset_state("async_run");
      @(negedge clock);
      reset = 1'b0;
      prog_q = '{32'hcafef00d, 32'h0badbeef};
      run_program(2, 1'b1, 1);
      stop_run();

      repeat (3) @(negedge clock);
      $display("%0d/%0d checks passed", n_pass, n_total);
      $finish;
   end

endmodule

// File: doc/instr_image_loader.md
Name: instr_image_loader

Overview:
- Writer side of the CPU's `instr`/`start` program interface.
- Accepts 32-bit instruction words one at a time over a valid/ready stream and packs them into the CPU's flat instruction image bus.
- Zero-pads unused slots, then raises `start` so the CPU begins fetching from slot 0.
- Sits between the bench or boot-source and the CPU; the CPU only ever sees a complete, stable image.

Parameters:
- NUM_SLOTS, 10, number of 32-bit instruction slots in the image.
- WORD_W, 32, instruction width.
- IMG_W, NUM_SLOTS*WORD_W (320), width of the packed image bus. Derived; must not be overridden.

Ports:
- clock  in  1  sole clock, rising edge.
- reset  in  1  asynchronous, active-high reset.
- in_valid  in  1  `in_data` holds a word to load.
- in_ready  out  1  loader can accept a word this cycle.
- in_data  in  WORD_W  instruction word.
- in_last  in  1  qualifies `in_data` as the final program word.
- run_stop  in  1  single-cycle request to drop `start` and return to IDLE.
- instr  out  IMG_W  packed image. Slot k occupies bits [IMG_W-1-WORD_W*k -: WORD_W], so slot 0 is at [319:288].
- start  out  1  high while the CPU may execute the image.
- words_loaded  out  4  count of words accepted for the current image (0..NUM_SLOTS).
- busy  out  1  high in LOAD or PAD.

Behaviour:
- Reset (async assert, sync release):
  - State = IDLE; `instr` = 0; `start` = 0; `words_loaded` = 0; `in_ready` = 1; `busy` = 0.
- A transfer occurs on a rising edge where `in_valid && in_ready`.
- IDLE:
  - `in_ready` = 1.
  - On the first transfer: clear the whole image, write the word to slot 0, set `words_loaded` = 1.
  - If `in_last` is set, or NUM_SLOTS == 1, go to PAD. Otherwise go to LOAD.
- LOAD:
  - `in_ready` = 1.
  - Each transfer writes slot `words_loaded` and increments the count.
  - Go to PAD when the transfer has `in_last` = 1, or when the count reaches NUM_SLOTS.
  - The word carried with `in_last` is written before leaving.
- PAD:
  - `in_ready` = 0.
  - Slot index `words_loaded`..NUM_SLOTS-1 are zero-filled, one slot per cycle (0x00000000 = nop).
  - The slot index counter is separate; `words_loaded` keeps the real count.
  - When no slots remain (including a full image), go to RUN on the next edge.
  - PAD always lasts at least 1 cycle.
- RUN:
  - `start` = 1 (registered, so it rises the cycle after entering RUN); `in_ready` = 0; `instr` is frozen.
  - `run_stop` = 1 → IDLE: `start` = 0 next cycle, image retained, `words_loaded` retained until the next first transfer.
- Boundary conditions:
  - A full image (10 words without `in_last`) goes to PAD with zero slots to fill, then 1 cycle later to RUN.
  - An 11th word is impossible because `in_ready` = 0 once the count reaches NUM_SLOTS.
  - `in_valid` while `in_ready` = 0 is ignored; `in_data` is not sampled.
  - `in_last` with `in_valid` = 0 is ignored.
  - `run_stop` outside RUN is ignored.
  - `run_stop` and `in_valid` in the same RUN cycle: stop is taken, the word is not accepted (`in_ready` = 0).
  - Reset mid-LOAD, mid-PAD or mid-RUN returns immediately to IDLE with `instr` = 0 and `start` = 0.
- Arithmetic:
  - `words_loaded` and the slot index are 4-bit and saturate at NUM_SLOTS.
  - Slot writes never index outside [0, NUM_SLOTS-1].
- Latency:
  - Last accepted word at edge N → `start` = 1 after edge N + 1 + (NUM_SLOTS − count) + 1.
  - For a 9-word program: N+3.

Decomposition:
- Shared package (`cpu_pkg`):
  - WORD_W, NUM_SLOTS, NOP_WORD (32'h0).
  - State enum: IDLE, LOAD, PAD, RUN.
  - Slot-offset function: slot k → bit base IMG_W−WORD_W*(k+1).
- One natural sub-module: `slot_writer`.
  - Holds the IMG_W register with per-slot write enable, data mux (input word vs NOP_WORD) and clear.
  - The FSM and counters stay in `instr_image_loader`.

Test Plan:
- Nine-word program: addi gr1,gr0,3 = 0x20010003 ... sub gr7,gr4,gr6 = 0x00863822, `in_last` on word 9 → slot 0 = 0x20010003, slot 8 = 0x00863822, [31:0] = 0, `words_loaded` = 9, `start` = 1 three cycles after the last transfer.
- Ten words, no `in_last` → `in_ready` drops after the 10th transfer, `instr` equals the concatenation in order, `start` = 1 two cycles later; an 11th `in_valid` is not accepted.
- Single word 0x08000001 with `in_last` → slot 0 set, slots 1..9 zero after 9 PAD cycles, `start` = 1 at edge N+11.
- `in_valid` toggled with gaps and held high while `in_ready` = 0 → only handshaken words appear, in order, with no duplicates.
- In RUN, pulse `run_stop` → `start` = 0 next cycle, `instr` unchanged. Then load one new word 0x20220001 → whole image cleared, slot 0 = 0x20220001.
- Assert `reset` asynchronously mid-LOAD, after 4 words → `instr` = 0, `start` = 0, `words_loaded` = 0 before the next clock edge; reload works normally.
